score_ctrl: RTL and testbench

//   Scheduler between the four scoreboard buttons (team A/B up/down) plus a clear

---
 rtl/score_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_score_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : score_ctrl
// Description : Scheduler between the scoreboard buttons (A/B up/down, clear)
//               and two external saturating score counters. Buttons are
//               synchronised, edge-detected and queued as pending requests,
//               which are served one at a time in round-robin order. A clear
//               sequence runs automatically after power-up.
// Revision    : 1.0 - initial release
// ============================================================================
module score_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int STROBE_LEN  = 2,
    parameter int GAP_LEN     = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_a_up_i,
    input  logic btn_a_dn_i,
    input  logic btn_b_up_i,
    input  logic btn_b_dn_i,
    input  logic clr_i,
    output logic cnt_a_clk_o,
    output logic cnt_a_mod_o,
    output logic cnt_b_clk_o,
    output logic cnt_b_mod_o,
    output logic cnt_rst_o,
    output logic busy_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_PULSE     = 3'd2,
        S_GAP       = 3'd3,
        S_CLR_SETUP = 3'd4,
        S_CLR_PULSE = 3'd5,
        S_CLR_GAP   = 3'd6
    } state_t;

    // Request bit order: [0]=A_UP [1]=A_DN [2]=B_UP [3]=B_DN [4]=CLEAR
    localparam logic [7:0] c_STROBE_LAST = 8'(STROBE_LEN - 1);
    localparam logic [7:0] c_GAP_LAST    = 8'(GAP_LEN - 1);

    logic [4:0] w_btn;
    logic [4:0] r_sync [SYNC_STAGES];
    logic [4:0] r_prev;
    logic [4:0] w_rise;

    state_t     r_state;
    logic       r_boot;
    logic [7:0] r_cnt;
    logic [4:0] r_pend;
    logic [1:0] r_ptr;
    logic [1:0] r_gnt;
    logic       r_a_clk;
    logic       r_a_mod;
    logic       r_b_clk;
    logic       r_b_mod;
    logic       r_cnt_rst;
    logic       r_busy;

    logic       w_any;
    logic [1:0] w_gnt_idx;
    logic [1:0] w_probe;
    logic [3:0] w_gnt_oh;

    assign w_btn  = {clr_i, btn_b_dn_i, btn_b_up_i, btn_a_dn_i, btn_a_up_i};
    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Button synchronisers and previous-value register for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= w_btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Round-robin pick: first pending count slot at or after the pointer
    always_comb begin
        w_any     = |r_pend[3:0];
        w_gnt_idx = r_ptr;
        w_probe   = r_ptr;
        // Walk offsets from far to near so the nearest pending slot wins
        for (int i = 3; i >= 0; i--) begin
            w_probe = r_ptr + 2'(i);
            if (r_pend[w_probe]) begin
                w_gnt_idx = w_probe;
            end
        end
        w_gnt_oh = 4'b0001 << w_gnt_idx;
    end

    // Sequencer: pending queue, grant pointer and registered counter controls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_CLR_SETUP;
            r_boot    <= 1'b1;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_ptr     <= 2'd0;
            r_gnt     <= 2'd0;
            r_a_clk   <= 1'b0;
            r_a_mod   <= 1'b0;
            r_b_clk   <= 1'b0;
            r_b_mod   <= 1'b0;
            r_cnt_rst <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // New presses are always recorded; states below may clear bits first
            r_pend <= r_pend | w_rise;
            case (r_state)
                S_IDLE: begin
                    if (r_pend[4]) begin
                        r_state   <= S_CLR_SETUP;
                        r_cnt_rst <= 1'b1;
                        r_busy    <= 1'b1;
                    end else if (w_any) begin
                        r_state <= S_SETUP;
                        r_gnt   <= w_gnt_idx;
                        r_ptr   <= w_gnt_idx + 2'd1;
                        r_busy  <= 1'b1;
                        // A same-cycle press on the granted slot survives
                        r_pend  <= (r_pend & ~{1'b0, w_gnt_oh}) | w_rise;
                        if (!w_gnt_idx[1]) begin
                            r_a_mod <= ~w_gnt_idx[0];
                        end else begin
                            r_b_mod <= ~w_gnt_idx[0];
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_PULSE;
                    r_cnt   <= '0;
                    r_a_clk <= ~r_gnt[1];
                    r_b_clk <= r_gnt[1];
                end
                S_PULSE: begin
                    if (r_cnt == c_STROBE_LAST) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                        r_a_clk <= 1'b0;
                        r_b_clk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_CLR_SETUP: begin
                    // Everything queued so far is discarded by the clear
                    r_pend    <= w_rise;
                    r_cnt_rst <= 1'b1;
                    r_busy    <= 1'b1;
                    if (r_boot) begin
                        // First cycle after reset only raises cnt_rst_o; stay here
                        r_boot <= 1'b0;
                    end else begin
                        r_state <= S_CLR_PULSE;
                        r_cnt   <= '0;
                        r_a_clk <= 1'b1;
                        r_b_clk <= 1'b1;
                    end
                end
                S_CLR_PULSE: begin
                    if (r_cnt == c_STROBE_LAST) begin
                        r_state <= S_CLR_GAP;
                        r_cnt   <= '0;
                        r_a_clk <= 1'b0;
                        r_b_clk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_CLR_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_state   <= S_IDLE;
                        r_cnt_rst <= 1'b0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_a_clk   <= 1'b0;
                    r_b_clk   <= 1'b0;
                    r_cnt_rst <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_a_clk_o = r_a_clk;
    assign cnt_a_mod_o = r_a_mod;
    assign cnt_b_clk_o = r_b_clk;
    assign cnt_b_mod_o = r_b_mod;
    assign cnt_rst_o   = r_cnt_rst;
    assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_score_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_ctrl
// Description : Self-checking bench for score_ctrl. Models both external
//               saturating counters and predicts the strobe order with an
//               independent round-robin model feeding a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_ctrl;

    localparam int STROBE_LEN = 2;

    typedef struct packed {
        logic [1:0] kind;   // 0=A, 1=B, 2=clear (both)
        logic       mod;
    } ev_t;

    typedef struct {
        logic [4:0] mask;   // [0]A_UP [1]A_DN [2]B_UP [3]B_DN [4]CLR
        int         exp_a;
        int         exp_b;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic btn_a_up = 1'b0, btn_a_dn = 1'b0, btn_b_up = 1'b0, btn_b_dn = 1'b0, clr = 1'b0;
    logic cnt_a_clk, cnt_a_mod, cnt_b_clk, cnt_b_mod, cnt_rst, busy;

    int checks = 0;
    int errors = 0;
    int m_a = 42;
    int m_b = 17;
    int ptr = 0;
    int n_a_ev = 0;
    ev_t exp_q[$];

    logic pa = 1'b0, pb = 1'b0;
    int   hi = 0;
    int   mon_kind = 0;
    logic mon_mod = 1'b0;

    score_ctrl #(.SYNC_STAGES(2), .STROBE_LEN(STROBE_LEN), .GAP_LEN(1)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .btn_a_up_i (btn_a_up),
        .btn_a_dn_i (btn_a_dn),
        .btn_b_up_i (btn_b_up),
        .btn_b_dn_i (btn_b_dn),
        .clr_i      (clr),
        .cnt_a_clk_o(cnt_a_clk),
        .cnt_a_mod_o(cnt_a_mod),
        .cnt_b_clk_o(cnt_b_clk),
        .cnt_b_mod_o(cnt_b_mod),
        .cnt_rst_o  (cnt_rst),
        .busy_o     (busy)
    );

    initial forever #5 clk = ~clk;

    // Models of the two external 0..99 saturating counters
    always @(posedge cnt_a_clk) begin
        if (cnt_rst)        m_a <= 0;
        else if (cnt_a_mod) m_a <= (m_a >= 99) ? 99 : m_a + 1;
        else                m_a <= (m_a == 0) ? 0 : m_a - 1;
    end
    always @(posedge cnt_b_clk) begin
        if (cnt_rst)        m_b <= 0;
        else if (cnt_b_mod) m_b <= (m_b >= 99) ? 99 : m_b + 1;
        else                m_b <= (m_b == 0) ? 0 : m_b - 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Strobe monitor: scoreboard pops, pulse width, mod stability, exclusivity
    always @(negedge clk) begin
        if (!rst_ni) begin
            pa = 1'b0; pb = 1'b0; hi = 0;
        end else begin
            if ((cnt_a_clk && !pa) || (cnt_b_clk && !pb)) begin
                ev_t e;
                mon_kind = (cnt_a_clk && cnt_b_clk) ? 2 : (cnt_a_clk ? 0 : 1);
                mon_mod  = (mon_kind == 0) ? cnt_a_mod : cnt_b_mod;
                hi = 1;
                if (mon_kind == 0) n_a_ev++;
                check("rst_level_at_strobe", int'(cnt_rst), (mon_kind == 2) ? 1 : 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe_kind", mon_kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", mon_kind, int'(e.kind));
                    if (mon_kind != 2) check("strobe_mod", int'(mon_mod), int'(e.mod));
                end
            end else if (cnt_a_clk || cnt_b_clk) begin
                hi++;
                if (mon_kind == 0) check("a_mod_stable", int'(cnt_a_mod), int'(mon_mod));
                if (mon_kind == 1) check("b_mod_stable", int'(cnt_b_mod), int'(mon_mod));
                if (cnt_a_clk && cnt_b_clk) check("overlap_only_in_clear", int'(cnt_rst), 1);
            end else if (pa || pb) begin
                check("strobe_width", hi, STROBE_LEN);
            end
            pa = cnt_a_clk;
            pb = cnt_b_clk;
        end
    end

    // Independent round-robin prediction for presses arriving together in IDLE
    task automatic push_expect(input logic [4:0] m);
        ev_t e;
        int  last;
        last = -1;
        if (m[4]) begin
            e.kind = 2'd2; e.mod = 1'b0;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < 4; i++) begin
                int s;
                s = (ptr + i) % 4;
                if (m[s]) begin
                    e.kind = (s < 2) ? 2'd0 : 2'd1;
                    e.mod  = (s % 2 == 0);
                    exp_q.push_back(e);
                    last = s;
                end
            end
            if (last >= 0) ptr = (last + 1) % 4;
        end
    endtask

    task automatic set_btns(input logic [4:0] m);
        btn_a_up = m[0]; btn_a_dn = m[1]; btn_b_up = m[2]; btn_b_dn = m[3]; clr = m[4];
    endtask

    task automatic wait_quiet();
        int q = 0;
        int n = 0;
        while (q < 6 && n < 2000) begin
            @(negedge clk);
            n++;
            if (!busy) q++; else q = 0;
        end
        if (q < 6) check("quiet_timeout", 0, 1);
    endtask

    task automatic wait_strobe(input bit want_b);
        int n = 0;
        while (((want_b ? cnt_b_clk : cnt_a_clk) == 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("strobe_timeout", 0, 1);
    endtask

    task automatic press(input logic [4:0] m);
        push_expect(m);
        @(negedge clk);
        set_btns(m);
        repeat (2) @(negedge clk);
        set_btns(5'b0);
        wait_quiet();
    endtask

    task automatic check_auto_clear(input string tag);
        @(negedge clk);
        check({tag, "_busy_after_release"}, int'(busy), 1);
        check({tag, "_cnt_rst_setup"}, int'({cnt_rst, cnt_a_clk, cnt_b_clk}), 3'b100);
        @(negedge clk);
        check({tag, "_clr_pulse"}, int'({cnt_rst, cnt_a_clk, cnt_b_clk}), 3'b111);
        wait_quiet();
        check({tag, "_idle_outputs"},
              int'({cnt_a_clk, cnt_a_mod, cnt_b_clk, cnt_b_mod, cnt_rst, busy}), 0);
        check({tag, "_score_a"}, m_a, 0);
        check({tag, "_score_b"}, m_b, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   a_before;
        vecs[0] = '{5'b01000, 1, 0};   // B_DN at 0 stays 0; pointer wraps to A_UP
        vecs[1] = '{5'b01111, 1, 0};   // all four: A_UP, A_DN, B_UP, B_DN
        vecs[2] = '{5'b00010, 0, 0};
        vecs[3] = '{5'b00010, 0, 0};   // A_DN at 0 still strobed
        vecs[4] = '{5'b00101, 1, 1};   // pointer at B_UP: B_UP then A_UP
        vecs[5] = '{5'b01100, 1, 1};
        vecs[6] = '{5'b10000, 0, 0};   // clear

        // Power-up: outputs held low in reset, then automatic clear
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({cnt_a_clk, cnt_a_mod, cnt_b_clk, cnt_b_mod, cnt_rst, busy}), 0);
        push_expect(5'b10000);
        rst_ni = 1'b1;
        check_auto_clear("powerup");

        // Single A_UP press held 10 cycles: exact latency to strobe
        push_expect(5'b00001);
        @(negedge clk);
        btn_a_up = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_busy_before_setup", int'(busy), 0);
        @(negedge clk);
        check("lat_setup", int'({busy, cnt_a_mod, cnt_a_clk}), 3'b110);
        @(negedge clk);
        check("lat_strobe_rise", int'(cnt_a_clk), 1);
        repeat (5) @(negedge clk);
        btn_a_up = 1'b0;
        wait_quiet();
        check("single_up_score_a", m_a, 1);
        check("single_up_queue", exp_q.size(), 0);

        // Table of simultaneous-press patterns
        for (int v = 0; v < 7; v++) begin
            press(vecs[v].mask);
            check($sformatf("vec%0d_score_a", v), m_a, vecs[v].exp_a);
            check($sformatf("vec%0d_score_b", v), m_b, vecs[v].exp_b);
            check($sformatf("vec%0d_queue", v), exp_q.size(), 0);
        end

        // Clear pressed during a B_UP pulse, with an A_DN press to be dropped
        for (int i = 0; i < 5; i++) press(5'b00001);
        check("pre_clear_score_a", m_a, 5);
        push_expect(5'b00100);
        @(negedge clk);
        btn_b_up = 1'b1;
        wait_strobe(1'b1);
        btn_b_up = 1'b0;
        push_expect(5'b10000);
        clr = 1'b1;
        btn_a_dn = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        btn_a_dn = 1'b0;
        check("b_pulse_completed", m_b, 1);
        wait_quiet();
        check("clear_mid_score_a", m_a, 0);
        check("clear_mid_score_b", m_b, 0);
        check("clear_mid_queue", exp_q.size(), 0);

        // Saturation at 99 then one step down
        a_before = n_a_ev;
        for (int i = 0; i < 101; i++) press(5'b00001);
        check("sat_strobe_count", n_a_ev - a_before, 101);
        check("sat_score_a", m_a, 99);
        press(5'b00010);
        check("after_sat_dn_score_a", m_a, 98);

        // Asynchronous reset mid-pulse, then automatic clear again
        push_expect(5'b00001);
        @(negedge clk);
        btn_a_up = 1'b1;
        wait_strobe(1'b0);
        btn_a_up = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({cnt_a_clk, cnt_a_mod, cnt_b_clk, cnt_b_mod, cnt_rst, busy}), 0);
        check("async_reset_queue", exp_q.size(), 0);
        ptr = 0;
        push_expect(5'b10000);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        check_auto_clear("rerelease");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
